bus_ctrl: RTL and testbench

Two-master, two-slave bus controller. Arbitrates bus ownership between master 0 and master 1 with a registered grant FSM, routes the owning master's address, write-enable and write data to the slaves, and decodes the address to a slave select. It also returns slave read data to the masters with a registered select, matching the one-cycle read latency of the slave memories. It sits between the master blocks and the memory slaves, alongside the bus address decoder, as the bus top-level sequencer.

---
 rtl/bus_ctrl.sv | 153 +++++++++++++++
 tb/tb_bus_ctrl.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/bus_ctrl.sv
// -----------------------------------------------------------------------------
// bus_ctrl
// Two-master / two-slave bus sequencer. A registered two-state arbiter decides
// which master owns the bus, the owner's address / write enable / write data
// are routed to the slaves, the address is decoded to a slave select, and slave
// read data is returned to the masters through a registered select that lines
// up with the one-cycle read latency of the slave memories.
//
// Ports
//   clk, reset            : rising-edge clock, asynchronous active-high reset
//   m0_req/wr/address/dout: master 0 request, write enable, address, write data
//   m1_req/wr/address/dout: master 1 request, write enable, address, write data
//   m0_grant, m1_grant    : one-hot bus ownership (exactly one is always high)
//   m_din                 : read data returned to both masters
//   s_address, s_wr, s_din: owner's address, qualified write enable, write data
//   s0_sel, s1_sel        : slave selects (0x00-0x1F -> s0, 0x20-0x3F -> s1)
//   s0_dout, s1_dout      : slave read data, valid one cycle after the select
// -----------------------------------------------------------------------------
module bus_ctrl #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_wr,
   input  logic [ADDR_W-1:0] m0_address,
   input  logic [DATA_W-1:0] m0_dout,
   input  logic              m1_req,
   input  logic              m1_wr,
   input  logic [ADDR_W-1:0] m1_address,
   input  logic [DATA_W-1:0] m1_dout,
   output logic              m0_grant,
   output logic              m1_grant,
   output logic [DATA_W-1:0] m_din,
   output logic [ADDR_W-1:0] s_address,
   output logic              s_wr,
   output logic [DATA_W-1:0] s_din,
   output logic              s0_sel,
   output logic              s1_sel,
   input  logic [DATA_W-1:0] s0_dout,
   input  logic [DATA_W-1:0] s1_dout
);

   typedef enum logic [0:0] {
      M0_GRANT = 1'b0,
      M1_GRANT = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [1:0]  rd_sel_q, rd_sel_d;
   logic        req_s;
   logic        wr_s;

   // State and read-select registers; reset parks the bus on master 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= M0_GRANT;
         rd_sel_q <= 2'b00;
      end else begin
         state_q  <= state_d;
         rd_sel_q <= rd_sel_d;
      end
   end

   // Arbiter next state: no preemption, master 0 wins a tie from the parked state.
   always_comb begin
      state_d = state_q;
      case (state_q)
         M0_GRANT: begin
            if (!m0_req && m1_req) begin
               state_d = M1_GRANT;
            end else begin
               state_d = M0_GRANT;
            end
         end
         M1_GRANT: begin
            if (m1_req) begin
               state_d = M1_GRANT;
            end else begin
               state_d = M0_GRANT;
            end
         end
         default: state_d = M0_GRANT;
      endcase
   end

   assign m0_grant = (state_q == M0_GRANT);
   assign m1_grant = (state_q == M1_GRANT);

   // Route the owning master onto the slave side.
   always_comb begin
      req_s     = 1'b0;
      wr_s      = 1'b0;
      s_address = '0;
      s_din     = '0;
      case (state_q)
         M0_GRANT: begin
            req_s     = m0_req;
            wr_s      = m0_wr;
            s_address = m0_address;
            s_din     = m0_dout;
         end
         M1_GRANT: begin
            req_s     = m1_req;
            wr_s      = m1_wr;
            s_address = m1_address;
            s_din     = m1_dout;
         end
         default: begin
            req_s     = 1'b0;
            wr_s      = 1'b0;
            s_address = '0;
            s_din     = '0;
         end
      endcase
   end

   assign s_wr = wr_s & req_s;

   // Address decode; an idle owner or an unmapped address selects nothing.
   always_comb begin
      s0_sel = 1'b0;
      s1_sel = 1'b0;
      if (req_s && (s_address < ADDR_W'(6'd32))) begin
         s0_sel = 1'b1;
      end else if (req_s && (s_address < ADDR_W'(7'd64))) begin
         s1_sel = 1'b1;
      end else begin
         s0_sel = 1'b0;
         s1_sel = 1'b0;
      end
   end

   // Remember which slave was read this cycle; writes return nothing.
   always_comb begin
      if (s_wr) begin
         rd_sel_d = 2'b00;
      end else begin
         rd_sel_d = {s0_sel, s1_sel};
      end
   end

   // Read data return mux, driven by the select captured last cycle.
   always_comb begin
      case (rd_sel_q)
         2'b10:   m_din = s0_dout;
         2'b01:   m_din = s1_dout;
         default: m_din = '0;
      endcase
   end

endmodule

// File: tb/tb_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bus_ctrl
// Directed bench for bus_ctrl. Two small slave memories with one-cycle read
// latency sit on the slave side. A table of per-cycle stimulus / expected
// values is applied in a loop, followed by a hand-written reset-mid-read case.
// -----------------------------------------------------------------------------
module tb_bus_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        m0_req, m0_wr, m1_req, m1_wr;
   logic [7:0]  m0_address, m1_address;
   logic [31:0] m0_dout, m1_dout;
   logic        m0_grant, m1_grant;
   logic [31:0] m_din;
   logic [7:0]  s_address;
   logic        s_wr;
   logic [31:0] s_din;
   logic        s0_sel, s1_sel;
   logic [31:0] s0_dout, s1_dout;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   bus_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_wr(m0_wr), .m0_address(m0_address), .m0_dout(m0_dout),
      .m1_req(m1_req), .m1_wr(m1_wr), .m1_address(m1_address), .m1_dout(m1_dout),
      .m0_grant(m0_grant), .m1_grant(m1_grant), .m_din(m_din),
      .s_address(s_address), .s_wr(s_wr), .s_din(s_din),
      .s0_sel(s0_sel), .s1_sel(s1_sel),
      .s0_dout(s0_dout), .s1_dout(s1_dout)
   );

   // Slave memories: mem0[i] = 5000_00xx, mem1[i] = 6000_00xx after reset.
   logic [31:0] mem0 [32];
   logic [31:0] mem1 [32];

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            mem0[i] <= 32'h5000_0000 | 32'(i);
            mem1[i] <= 32'h6000_0000 | 32'(i);
         end
         s0_dout <= 32'h0;
         s1_dout <= 32'h0;
      end else begin
         if (s0_sel && s_wr) mem0[s_address[4:0]] <= s_din;
         if (s1_sel && s_wr) mem1[s_address[4:0]] <= s_din;
         s0_dout <= mem0[s_address[4:0]];
         s1_dout <= mem1[s_address[4:0]];
      end
   end

   typedef struct {
      logic        m0_req;
      logic        m0_wr;
      logic [7:0]  m0_addr;
      logic [31:0] m0_dout;
      logic        m1_req;
      logic        m1_wr;
      logic [7:0]  m1_addr;
      logic [31:0] m1_dout;
      logic        g0;
      logic        g1;
      logic        sel0;
      logic        sel1;
      logic        swr;
      logic [31:0] din;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_req = 1'b0; m0_wr = 1'b0; m0_address = 8'h00; m0_dout = 32'h0;
      m1_req = 1'b0; m1_wr = 1'b0; m1_address = 8'h00; m1_dout = 32'h0;
   endtask

   initial begin
      //           m0 req wr  addr   dout          m1 req wr  addr   dout          g0 g1 s0 s1 wr  din
      vecs.push_back('{1'b1,1'b1,8'h05,32'hA5A5_0001, 1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b1,32'h0});
      vecs.push_back('{1'b1,1'b0,8'h05,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b0,32'h0});
      vecs.push_back('{1'b1,1'b0,8'h05,32'h0,         1'b1,1'b0,8'h30,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b0,32'hA5A5_0001});
      vecs.push_back('{1'b0,1'b0,8'h05,32'h0,         1'b1,1'b0,8'h30,32'h0,          1'b1,1'b0,1'b0,1'b0,1'b0,32'hA5A5_0001});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h10,32'h0,          1'b0,1'b1,1'b1,1'b0,1'b0,32'h0});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h30,32'h0,          1'b0,1'b1,1'b0,1'b1,1'b0,32'h5000_0010});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h20,32'h0,          1'b0,1'b1,1'b0,1'b1,1'b0,32'h6000_0010});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h1F,32'h0,          1'b0,1'b1,1'b1,1'b0,1'b0,32'h6000_0000});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h3F,32'h0,          1'b0,1'b1,1'b0,1'b1,1'b0,32'h5000_001F});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h40,32'h0,          1'b0,1'b1,1'b0,1'b0,1'b0,32'h6000_001F});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h20,32'h0,          1'b0,1'b1,1'b0,1'b1,1'b0,32'h0});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b1,8'h21,32'hDEAD_BEEF,  1'b0,1'b1,1'b0,1'b1,1'b1,32'h6000_0000});
      vecs.push_back('{1'b1,1'b0,8'h21,32'h0,         1'b0,1'b0,8'h21,32'h0,          1'b0,1'b1,1'b0,1'b0,1'b0,32'h0});
      vecs.push_back('{1'b1,1'b0,8'h21,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b0,1'b1,1'b0,32'h0});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b0,1'b0,1'b0,32'hDEAD_BEEF});
      vecs.push_back('{1'b1,1'b0,8'h02,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b1,1'b0,1'b0,32'h0});
      vecs.push_back('{1'b0,1'b0,8'h02,32'h0,         1'b1,1'b0,8'h31,32'h0,          1'b1,1'b0,1'b0,1'b0,1'b0,32'h5000_0002});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b1,1'b0,8'h31,32'h0,          1'b0,1'b1,1'b0,1'b1,1'b0,32'h0});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b0,1'b1,1'b0,1'b0,1'b0,32'h6000_0011});
      vecs.push_back('{1'b0,1'b0,8'h00,32'h0,         1'b0,1'b0,8'h00,32'h0,          1'b1,1'b0,1'b0,1'b0,1'b0,32'h0});

      // Reset with both masters idle.
      idle_inputs();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_g0",   -1, 32'(m0_grant), 32'h1);
      chk("rst_g1",   -1, 32'(m1_grant), 32'h0);
      chk("rst_mdin", -1, m_din,         32'h0);
      chk("rst_sel0", -1, 32'(s0_sel),   32'h0);
      chk("rst_sel1", -1, 32'(s1_sel),   32'h0);
      chk("rst_swr",  -1, 32'(s_wr),     32'h0);
      reset = 1'b0;

      // Table: inputs applied just after an edge, outputs checked mid-cycle.
      foreach (vecs[i]) begin
         @(posedge clk);
         #1;
         m0_req = vecs[i].m0_req; m0_wr = vecs[i].m0_wr;
         m0_address = vecs[i].m0_addr; m0_dout = vecs[i].m0_dout;
         m1_req = vecs[i].m1_req; m1_wr = vecs[i].m1_wr;
         m1_address = vecs[i].m1_addr; m1_dout = vecs[i].m1_dout;
         @(negedge clk);
         chk("g0",   i, 32'(m0_grant), 32'(vecs[i].g0));
         chk("g1",   i, 32'(m1_grant), 32'(vecs[i].g1));
         chk("sel0", i, 32'(s0_sel),   32'(vecs[i].sel0));
         chk("sel1", i, 32'(s1_sel),   32'(vecs[i].sel1));
         chk("swr",  i, 32'(s_wr),     32'(vecs[i].swr));
         chk("mdin", i, m_din,         vecs[i].din);
         chk("saddr", i, 32'(s_address),
             32'(vecs[i].g0 ? vecs[i].m0_addr : vecs[i].m1_addr));
      end

      // Reset mid-read: master 1 reads 0x25, reset pulses between edges.
      @(posedge clk); #1;
      idle_inputs();
      m1_req = 1'b1; m1_address = 8'h25;
      @(posedge clk); #1;
      chk("mr_g1",   100, 32'(m1_grant), 32'h1);
      chk("mr_sel1", 100, 32'(s1_sel),   32'h1);
      @(posedge clk); #1;
      m1_req = 1'b0;
      chk("mr_data", 101, m_din, 32'h6000_0005);
      #1 reset = 1'b1;
      #1;
      chk("mr_rst_g0",   102, 32'(m0_grant), 32'h1);
      chk("mr_rst_g1",   102, 32'(m1_grant), 32'h0);
      chk("mr_rst_mdin", 102, m_din,         32'h0);
      reset = 1'b0;
      #1;
      chk("mr_post_g0",   103, 32'(m0_grant), 32'h1);
      chk("mr_post_mdin", 103, m_din,         32'h0);
      @(posedge clk); #1;
      chk("mr_next_g0", 104, 32'(m0_grant), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
